// File: rtl/npu_sequencer.sv
// npu_sequencer
// Layer-level control FSM for the NPU core. For every neuron pair it clears
// the datapath, streams N_INPUTS operand beats into both MACs, applies ReLU,
// loads the four result bytes into the output PISO, and then drains them into
// the output FIFO while honouring FIFO_FULL.
//
// Ports:
//   CLKEXT, RST            clock (rising edge) / async active-high reset
//   START, ABORT           run request (IDLE only) / synchronous abort
//   N_INPUTS, N_PAIRS      beats per pair (0 acts as 1) / pairs per run
//   CFG_SEL_OUT, CFG_BYPASS1, CFG_BYPASS2   configuration latched at START
//   IN_VALID / IN_READY    loader beat handshake
//   FIFO_FULL              output FIFO back-pressure
//   CON_SIG, SSFR          core control and configuration words
//   BUSY, DONE, PAIR_IDX   run status
module npu_sequencer #(
  parameter int CNT_W  = 10,
  parameter int PAIR_W = 8
) (
  input  logic              CLKEXT,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  N_INPUTS,
  input  logic [PAIR_W-1:0] N_PAIRS,
  input  logic [2:0]        CFG_SEL_OUT,
  input  logic              CFG_BYPASS1,
  input  logic              CFG_BYPASS2,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              FIFO_FULL,
  output logic [15:0]       CON_SIG,
  output logic [15:0]       SSFR,
  output logic              BUSY,
  output logic              DONE,
  output logic [PAIR_W-1:0] PAIR_IDX
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_MAC, S_RELU,
    S_LATCH, S_WRITE, S_SHIFT, S_NEXT, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [1:0]        byte_q, byte_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [CNT_W-1:0]  n_in_q, n_in_d;
  logic [PAIR_W-1:0] n_pair_q, n_pair_d;
  logic [2:0]        sel_q, sel_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;

  logic [CNT_W-1:0]  beat_inc;
  logic              rst_comp;

  assign beat_inc = beat_q + CNT_W'(1);

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    byte_d   = byte_q;
    pair_d   = pair_q;
    n_in_d   = n_in_q;
    n_pair_d = n_pair_q;
    sel_d    = sel_q;
    byp1_d   = byp1_q;
    byp2_d   = byp2_q;
    if (state_q != S_IDLE && ABORT) begin
      // Abort drops the run but keeps the latched configuration for readout.
      state_d = S_IDLE;
      beat_d  = '0;
      byte_d  = '0;
      pair_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (N_PAIRS == '0) begin
              state_d = S_FIN;
            end else begin
              state_d  = S_CLEAR;
              beat_d   = '0;
              byte_d   = '0;
              pair_d   = '0;
              // Store the effective beat count so MAC needs no special case.
              n_in_d   = (N_INPUTS == '0) ? CNT_W'(1) : N_INPUTS;
              n_pair_d = N_PAIRS;
              sel_d    = CFG_SEL_OUT;
              byp1_d   = CFG_BYPASS1;
              byp2_d   = CFG_BYPASS2;
            end
          end
        end
        S_CLEAR: state_d = S_LOAD;
        S_LOAD: begin
          if (IN_VALID) state_d = S_MAC;
        end
        S_MAC: begin
          beat_d  = beat_inc;
          state_d = (beat_inc == n_in_q) ? S_RELU : S_LOAD;
        end
        S_RELU: state_d = S_LATCH;
        S_LATCH: begin
          byte_d  = '0;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (!FIFO_FULL) state_d = (byte_q == 2'd3) ? S_NEXT : S_SHIFT;
        end
        S_SHIFT: begin
          byte_d  = byte_q + 2'd1;
          state_d = S_WRITE;
        end
        S_NEXT: begin
          if (pair_q == n_pair_q - PAIR_W'(1)) begin
            state_d = S_FIN;
          end else begin
            pair_d  = pair_q + PAIR_W'(1);
            beat_d  = '0;
            state_d = S_CLEAR;
          end
        end
        S_FIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge CLKEXT or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      byte_q   <= '0;
      pair_q   <= '0;
      n_in_q   <= '0;
      n_pair_q <= '0;
      sel_q    <= '0;
      byp1_q   <= 1'b0;
      byp2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      byte_q   <= byte_d;
      pair_q   <= pair_d;
      n_in_q   <= n_in_d;
      n_pair_q <= n_pair_d;
      sel_q    <= sel_d;
      byp1_q   <= byp1_d;
      byp2_q   <= byp2_d;
    end
  end

  // Output decode from the state register; only the buffer enable and the
  // FIFO write are qualified by their live handshake inputs.
  always_comb begin
    CON_SIG  = '0;
    IN_READY = 1'b0;
    case (state_q)
      S_CLEAR: begin
        CON_SIG[14] = 1'b1;
        CON_SIG[12] = 1'b1;
        CON_SIG[8]  = 1'b1;
      end
      S_LOAD: begin
        IN_READY    = IN_VALID;
        CON_SIG[15] = IN_VALID;
      end
      S_MAC:   CON_SIG[13] = 1'b1;
      S_RELU:  CON_SIG[11] = 1'b1;
      S_LATCH: CON_SIG[9]  = 1'b1;
      S_WRITE: CON_SIG[7]  = !FIFO_FULL;
      S_SHIFT: CON_SIG[10] = 1'b1;
      default: CON_SIG = '0;
    endcase
  end

  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);
  assign PAIR_IDX = pair_q;
  assign rst_comp = (state_q == S_CLEAR) && (pair_q == '0);
  assign SSFR     = {sel_q, byp1_q, byp2_q, BUSY, rst_comp, BUSY, 1'b0, 7'b0};

endmodule

// File: tb/tb_npu_sequencer.sv
module tb_npu_sequencer;

  logic        CLKEXT = 1'b0;
  logic        RST, START, ABORT;
  logic [9:0]  N_INPUTS;
  logic [7:0]  N_PAIRS;
  logic [2:0]  CFG_SEL_OUT;
  logic        CFG_BYPASS1, CFG_BYPASS2;
  logic        IN_VALID, IN_READY, FIFO_FULL;
  logic [15:0] CON_SIG, SSFR;
  logic        BUSY, DONE;
  logic [7:0]  PAIR_IDX;

  int total = 0;
  int bad   = 0;

  npu_sequencer #(.CNT_W(10), .PAIR_W(8)) dut (
    .CLKEXT(CLKEXT), .RST(RST), .START(START), .ABORT(ABORT),
    .N_INPUTS(N_INPUTS), .N_PAIRS(N_PAIRS), .CFG_SEL_OUT(CFG_SEL_OUT),
    .CFG_BYPASS1(CFG_BYPASS1), .CFG_BYPASS2(CFG_BYPASS2),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FIFO_FULL(FIFO_FULL),
    .CON_SIG(CON_SIG), .SSFR(SSFR), .BUSY(BUSY), .DONE(DONE), .PAIR_IDX(PAIR_IDX)
  );

  always #5 CLKEXT = ~CLKEXT;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The model walks the run as a program: pairs, beats, bytes. Each call to
  // cyc() is one clock cycle with the outputs that cycle must show.
  logic [2:0] m_sel;
  logic       m_b1, m_b2;
  int         m_pair;
  bit         ab;
  bit         s_start, s_vin, s_full;
  int         s_ni, s_np;
  logic [2:0] s_sel;
  logic       s_b1, s_b2;

  localparam logic [15:0] W_CLEAR = 16'h5100;  // CLR_BUF_IN, RST_MAC, CLR_PISO_OUT
  localparam logic [15:0] W_MAC   = 16'h2000;
  localparam logic [15:0] W_RELU  = 16'h0800;
  localparam logic [15:0] W_LATCH = 16'h0200;
  localparam logic [15:0] W_SHIFT = 16'h0400;

  task automatic cyc(input logic [15:0] con, input bit clr, input bit busy,
                     input bit done, input bit ld, input bit wr);
    logic [15:0] e_con, e_ssfr;
    logic        e_rdy;
    @(negedge CLKEXT);
    if (!RST) begin
      e_con = con;
      e_rdy = ld && IN_VALID;
      if (e_rdy) e_con[15] = 1'b1;
      if (wr && !FIFO_FULL) e_con[7] = 1'b1;
      e_ssfr = {m_sel, m_b1, m_b2, busy, clr && (m_pair == 0), busy, 1'b0, 7'b0};
      chk("model", {21'b0, CON_SIG, SSFR, IN_READY, BUSY, DONE, PAIR_IDX},
          {21'b0, e_con, e_ssfr, e_rdy, busy, done, 8'(m_pair)});
    end
    @(posedge CLKEXT);
    s_start = START;
    s_vin   = IN_VALID;
    s_full  = FIFO_FULL;
    s_ni    = int'(N_INPUTS);
    s_np    = int'(N_PAIRS);
    s_sel   = CFG_SEL_OUT;
    s_b1    = CFG_BYPASS1;
    s_b2    = CFG_BYPASS2;
    if (RST) begin
      ab = 1;
      m_sel = '0; m_b1 = 1'b0; m_b2 = 1'b0; m_pair = 0;
    end else if (busy && ABORT) begin
      ab = 1;
    end
  endtask

  initial begin : model
    int np, ni;
    m_sel = '0; m_b1 = 1'b0; m_b2 = 1'b0; m_pair = 0;
    forever begin
      ab = 0;
      cyc(16'h0, 0, 0, 0, 0, 0);
      if (!ab && s_start) begin
        if (s_np == 0) begin
          cyc(16'h0, 0, 1, 1, 0, 0);
        end else begin
          m_sel = s_sel; m_b1 = s_b1; m_b2 = s_b2;
          np = s_np;
          ni = (s_ni == 0) ? 1 : s_ni;
          m_pair = 0;
          for (int p = 0; p < np && !ab; p++) begin
            m_pair = p;
            cyc(W_CLEAR, 1, 1, 0, 0, 0);
            for (int b = 0; b < ni && !ab; b++) begin
              do cyc(16'h0, 0, 1, 0, 1, 0); while (!ab && !s_vin);
              if (!ab) cyc(W_MAC, 0, 1, 0, 0, 0);
            end
            if (!ab) cyc(W_RELU, 0, 1, 0, 0, 0);
            if (!ab) cyc(W_LATCH, 0, 1, 0, 0, 0);
            for (int k = 0; k < 4 && !ab; k++) begin
              do cyc(16'h0, 0, 1, 0, 0, 1); while (!ab && s_full);
              if (!ab && k < 3) cyc(W_SHIFT, 0, 1, 0, 0, 0);
            end
            if (!ab) cyc(16'h0, 0, 1, 0, 0, 0);
          end
          if (!ab) cyc(16'h0, 0, 1, 1, 0, 0);
        end
        if (ab) m_pair = 0;
      end
    end
  end

  // ---------------- run trace for hand-computed checks ----------------
  logic [15:0] t_con  [0:2047];
  logic [15:0] t_ssfr [0:2047];
  logic [7:0]  t_pair [0:2047];

  // Called at posedge+1 with the DUT idle. Cycle 1 is the cycle after the
  // edge that samples START.
  task automatic run_trace(input int maxc, input int vlo_a, input int vlo_b,
                           input int fh_a, input int fh_b, input bit rnd,
                           output int done_c);
    for (int i = 0; i < 2048; i++) begin
      t_con[i] = '0; t_ssfr[i] = '0; t_pair[i] = '0;
    end
    START = 1'b1;
    @(posedge CLKEXT); #1;
    START = 1'b0;
    done_c = -1;
    for (int c = 1; c <= maxc; c++) begin
      if (rnd) begin
        IN_VALID  = ($urandom_range(0, 3) != 0);
        FIFO_FULL = ($urandom_range(0, 3) == 0);
        START     = ($urandom_range(0, 9) == 0);
      end else begin
        IN_VALID  = !(c >= vlo_a && c <= vlo_b);
        FIFO_FULL = (c >= fh_a && c <= fh_b);
      end
      @(negedge CLKEXT);
      t_con[c] = CON_SIG; t_ssfr[c] = SSFR; t_pair[c] = PAIR_IDX;
      if (DONE) begin
        done_c = c;
        break;
      end
      @(posedge CLKEXT); #1;
    end
    chk("done_seen", {63'b0, done_c > 0}, 64'd1);
    if (done_c > 0) begin
      @(posedge CLKEXT); #1;
    end
    START = 1'b0;
    IN_VALID = 1'b1;
    FIFO_FULL = 1'b0;
  endtask

  function automatic logic [63:0] con_mask(input int bitn, input int last);
    logic [63:0] m;
    m = '0;
    for (int c = 1; c <= last && c < 64; c++) if (t_con[c][bitn]) m[c] = 1'b1;
    return m;
  endfunction

  function automatic int cnt_bit(input bit use_ssfr, input int bitn, input int last);
    int n;
    n = 0;
    for (int c = 1; c <= last && c < 2048; c++)
      if (use_ssfr ? t_ssfr[c][bitn] : t_con[c][bitn]) n++;
    return n;
  endfunction

  task automatic cfg(input int ni, input int np, input logic [2:0] sel,
                     input logic b1, input logic b2);
    N_INPUTS = 10'(ni); N_PAIRS = 8'(np);
    CFG_SEL_OUT = sel; CFG_BYPASS1 = b1; CFG_BYPASS2 = b2;
  endtask

  initial begin : watchdog
    #300000;
    bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d;
    bit found;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    IN_VALID = 1'b1; FIFO_FULL = 1'b0;
    cfg(0, 0, 3'd0, 1'b0, 1'b0);
    @(negedge CLKEXT);
    chk("reset_outputs", {21'b0, CON_SIG, SSFR, IN_READY, BUSY, DONE, PAIR_IDX}, 64'd0);
    repeat (2) @(posedge CLKEXT);
    #1 RST = 1'b0;
    @(posedge CLKEXT); #1;

    // Single pair, three beats, no stalls.
    cfg(3, 1, 3'd5, 1'b1, 1'b0);
    run_trace(100, 0, -1, 0, -1, 0, d);
    chk("a_en_mac",  con_mask(13, d), 64'h00000000000000A8);
    chk("a_en_relu", con_mask(11, d), 64'h0000000000000100);
    chk("a_en_piso", con_mask(9, d),  64'h0000000000000200);
    chk("a_wr_en",   con_mask(7, d),  64'h0000000000015400);
    chk("a_done",    64'(d), 64'd18);
    chk("a_ssfr_clear", {48'b0, t_ssfr[1]}, 64'h000000000000B700);

    // Three pairs, two beats each.
    cfg(2, 3, 3'd2, 1'b0, 1'b1);
    run_trace(200, 0, -1, 0, -1, 0, d);
    chk("b_done",     64'(d), 64'd46);
    chk("b_rst_comp", 64'(cnt_bit(1, 9, d)), 64'd1);
    chk("b_wr_cnt",   64'(cnt_bit(0, 7, d)), 64'd12);
    chk("b_pair0",    {56'b0, t_pair[1]},  64'd0);
    chk("b_pair1",    {56'b0, t_pair[16]}, 64'd1);
    chk("b_pair2",    {56'b0, t_pair[31]}, 64'd2);

    // Same run with a 5-cycle LOAD stall and a 4-cycle FULL stall.
    run_trace(200, 4, 8, 17, 20, 0, d);
    chk("c_done",    64'(d), 64'd55);
    chk("c_mac_cnt", 64'(cnt_bit(0, 13, d)), 64'd6);
    chk("c_wr_cnt",  64'(cnt_bit(0, 7, d)),  64'd12);

    // N_INPUTS=0 behaves as one beat; N_PAIRS=0 finishes at once.
    cfg(0, 1, 3'd1, 1'b1, 1'b1);
    run_trace(100, 0, -1, 0, -1, 0, d);
    chk("d_done_n0",  64'(d), 64'd14);
    chk("d_mac_n0",   64'(cnt_bit(0, 13, d)), 64'd1);
    cfg(4, 0, 3'd6, 1'b0, 1'b0);
    run_trace(20, 0, -1, 0, -1, 0, d);
    chk("d_done_p0",  64'(d), 64'd1);
    chk("d_con_p0",   {48'b0, t_con[1]}, 64'd0);

    // Abort while shifting, then restart.
    cfg(1, 2, 3'd3, 1'b0, 1'b0);
    START = 1'b1;
    @(posedge CLKEXT); #1;
    START = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLKEXT);
      if (CON_SIG[10]) begin
        found = 1;
        break;
      end
      @(posedge CLKEXT); #1;
    end
    chk("e_shift_seen", {63'b0, found}, 64'd1);
    #2 ABORT = 1'b1;
    @(posedge CLKEXT); #1;
    ABORT = 1'b0;
    @(negedge CLKEXT);
    chk("e_after_abort", {46'b0, BUSY, DONE, CON_SIG}, 64'd0);
    @(posedge CLKEXT); #1;
    cfg(1, 1, 3'd3, 1'b0, 1'b0);
    run_trace(100, 0, -1, 0, -1, 0, d);
    chk("e_restart_pair", {56'b0, t_pair[1]}, 64'd0);
    chk("e_restart_rstcomp", {63'b0, t_ssfr[1][9]}, 64'd1);
    chk("e_restart_done", 64'(d), 64'd14);

    // Asynchronous reset while waiting in LOAD.
    cfg(2, 2, 3'd7, 1'b1, 1'b1);
    IN_VALID = 1'b0;
    START = 1'b1;
    @(posedge CLKEXT); #1;
    START = 1'b0;
    repeat (3) @(negedge CLKEXT);
    chk("f_in_load", {47'b0, BUSY, CON_SIG}, 64'h0000000000010000);
    #2 RST = 1'b1;
    #1;
    chk("f_async_reset", {29'b0, CON_SIG, SSFR, BUSY, IN_READY, DONE}, 64'd0);
    @(posedge CLKEXT);
    @(posedge CLKEXT); #1;
    RST = 1'b0;
    IN_VALID = 1'b1;
    @(posedge CLKEXT); #1;

    // Randomised runs with random stalls and stray START pulses.
    for (int r = 0; r < 8; r++) begin
      cfg($urandom_range(0, 4), $urandom_range(0, 3), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_trace(1500, 0, -1, 0, -1, 1, d);
      repeat ($urandom_range(0, 3)) @(posedge CLKEXT);
      #1;
    end

    repeat (3) @(posedge CLKEXT);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_sequencer.md
# npu_sequencer

Layer-level control FSM that drives the NPU core's CON_SIG and SSFR control words. For each neuron pair it clears the datapath, streams N_INPUTS operand beats through the input buffer into both MACs, applies ReLU, and loads the 4 result bytes into the output PISO. It then drains those bytes into the output FIFO under FULL back-pressure. It sits between the host/loader interface and the core, replacing software-driven control words.

## Interface
- CNT_W, 10, width of the input-beat counter and N_INPUTS
- PAIR_W, 8, width of the pair counter, N_PAIRS and PAIR_IDX
- CLKEXT  in  1  single clock; all logic is rising-edge
- RST  in  1  reset, asynchronous and active-high
- START  in  1  run request; sampled only in IDLE
- ABORT  in  1  synchronous abort; highest priority after RST
- N_INPUTS  in  CNT_W  MAC beats per pair; 0 is treated as 1
- N_PAIRS  in  PAIR_W  neuron pairs per run
- CFG_SEL_OUT  in  3  output mux select; latched at START
- CFG_BYPASS1, CFG_BYPASS2  in  1 each  ReLU bypass bits; latched at START
- IN_VALID  in  1  loader has the DA..DD beat on the core inputs
- IN_READY  out  1  beat accepted this cycle
- FIFO_FULL  in  1  core FULL flag
- CON_SIG  out  16  core control word; bits [6:0] always 0
- SSFR  out  16  core configuration word; bits [6:0] always 0
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at the end of a run
- PAIR_IDX  out  PAIR_W  index of the current pair, 0-based

## Operation
- CON_SIG bit map: 15 EN_BUF_IN, 14 CLR_BUF_IN, 13 EN_MAC, 12 RST_MAC, 11 EN_reLU, 10 SHIFT_OUT, 9 EN_PISO_OUT, 8 CLR_PISO_OUT, 7 WR_EN.
- SSFR bit map: [15:13] SEL_OUT, 12 BYPASS1, 11 BYPASS2, 10 EN_COMP, 9 RST_COMP, 8 EN_FIFO, 7 RST_FIFO.
- SSFR while BUSY:
  - [15:11] come from the values latched at START.
  - EN_COMP=1 and EN_FIFO=1.
  - RST_FIFO=0.
- SSFR in IDLE: holds the last latched SEL_OUT and bypass bits, so host readout still works; all other bits are 0.
- States: IDLE, CLEAR, LOAD, MAC, RELU, LATCH, WRITE, SHIFT, NEXT, FIN.
- IDLE:
  - START=1 and N_PAIRS=0: go to FIN; no datapath strobes are issued.
  - START=1 otherwise: latch configuration, clear both counters, go to CLEAR.
- CLEAR (1 cycle): CLR_BUF_IN=1, RST_MAC=1, CLR_PISO_OUT=1. RST_COMP=1 only when PAIR_IDX=0. Then go to LOAD.
- LOAD: EN_BUF_IN = IN_READY = IN_VALID. Move to MAC on a handshake; otherwise wait.
- MAC (1 cycle): EN_MAC=1 and the beat counter increments.
  - Counter reached effective N_INPUTS: go to RELU.
  - Otherwise: go to LOAD.
- RELU (1 cycle): EN_reLU=1. This also triggers the comparator.
- LATCH (1 cycle): EN_PISO_OUT=1, byte counter = 0.
- WRITE: WR_EN = !FIFO_FULL. After a write:
  - byte counter < 3: go to SHIFT.
  - byte counter = 3: go to NEXT.
  - FIFO_FULL=1: stall with no write.
- SHIFT (1 cycle): SHIFT_OUT=1, byte counter increments, go to WRITE.
- NEXT (1 cycle):
  - PAIR_IDX = N_PAIRS-1: go to FIN.
  - Otherwise: PAIR_IDX increments, beat counter clears, go to CLEAR.
- FIN (1 cycle): DONE=1, then go to IDLE.
- ABORT in any non-IDLE state:
  - Next state is IDLE.
  - DONE is not pulsed.
  - Counters clear; latched configuration is kept.
  - ABORT in IDLE is ignored.
- START outside IDLE is ignored.
- Strobe width: every CON_SIG strobe except EN_BUF_IN and WR_EN is exactly one cycle, decoded from the state register.
  - EN_BUF_IN is qualified by IN_VALID.
  - WR_EN is qualified by !FIFO_FULL.

## Timing
- Reset values: state IDLE; CON_SIG=0, SSFR=0, IN_READY=0, BUSY=0, DONE=0, PAIR_IDX=0; both counters and the latched configuration are 0.
- RST mid-run: all outputs go to reset values asynchronously.
- START sampled at edge E0 → CLEAR during the cycle after E0.
- Cycles per pair with no stalls: 2·N+11 (CLEAR 1, LOAD/MAC 2N, RELU 1, LATCH 1, WRITE/SHIFT 7, NEXT 1).
- DONE rises in the cycle after the last NEXT.
- LOAD and WRITE stalls add one cycle each per stalled cycle; no beat or byte is ever lost or duplicated.
- Buffer-to-MAC latency: a beat accepted in LOAD is in the buffer registers for the following MAC cycle.
- ReLU-to-PISO latency: ReLU output registers update at the end of RELU; PISO loads at the end of LATCH.
- Byte order into the FIFO follows PISO shift order: reLU1[7:0], reLU1[15:8], reLU2[7:0], reLU2[15:8].

## Test plan
- N_INPUTS=3, N_PAIRS=1, IN_VALID=1, FULL=0, START at E0 → EN_MAC high in cycles 3, 5, 7; EN_reLU in cycle 8; EN_PISO_OUT in cycle 9; WR_EN in cycles 10, 12, 14, 16; DONE in cycle 18.
- N_INPUTS=2, N_PAIRS=3, IN_VALID=1 → RST_COMP in the first CLEAR only; PAIR_IDX steps 0, 1, 2; exactly 12 WR_EN pulses; DONE after 3·15+1 cycles.
- IN_VALID low for 5 cycles in the second LOAD and FULL high for 4 cycles in the third WRITE → exactly N EN_MAC and 4 WR_EN pulses per pair; DONE delayed by exactly 9 cycles.
- N_INPUTS=0 → behaves as 1. N_PAIRS=0 → DONE one cycle after START with CON_SIG=0 throughout.
- ABORT asserted in SHIFT → IDLE next cycle, BUSY=0, no DONE. A new START then restarts with PAIR_IDX=0 and RST_COMP asserted.
- RST pulsed mid-LOAD → CON_SIG, SSFR, BUSY go to 0 immediately. START asserted while BUSY → ignored (no restart, no second DONE).
